// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: three-state sequencer (IDLE -> EXEC -> DONE) that decodes one
// instruction at a time, drives an external combinational ALU from an 8 x 8-bit
// register file, and writes the ALU result back on the EXEC->DONE edge.
//
// Handshake: an instruction transfers on a rising clk edge where instr_valid and
// instr_ready are both 1. instr_ready is 1 only in IDLE. Once an instruction is
// accepted, instr and instr_valid are ignored until the sequencer returns to IDLE.
// instr_valid may stay high across instructions.
module alu_op_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [7:0]  alu_data1,
    output logic [7:0]  alu_data2,
    output logic [2:0]  alu_select,
    input  logic [7:0]  alu_result,
    output logic        wb_valid,
    output logic [2:0]  wb_reg,
    output logic [7:0]  wb_data,
    output logic        illegal,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;

    state_t      state;
    logic [31:0] ir;
    logic [7:0]  regs [8];

    // Fields of the latched instruction; only bits [2:0] select a register.
    logic [7:0] opcode;
    logic [2:0] dest;
    logic [2:0] src1;
    logic [2:0] src2;
    logic [7:0] imm;
    logic       legal;

    assign opcode      = ir[31:24];
    assign dest        = ir[18:16];
    assign src1        = ir[10:8];
    assign src2        = ir[2:0];
    assign imm         = ir[7:0];
    assign legal       = (opcode <= OP_OR);

    assign instr_ready = (state == IDLE);
    assign dbg_state   = state;
    assign dbg_data    = regs[dbg_addr];

    // Operand and operation decode; the ALU sees zeros outside EXEC.
    always_comb begin
        alu_data1  = 8'd0;
        alu_data2  = 8'd0;
        alu_select = 3'd0;
        if (state == EXEC) begin
            case (opcode)
                OP_LOADI: begin
                    alu_select = 3'd0;
                    alu_data2  = imm;
                end
                OP_MOV: begin
                    alu_select = 3'd0;
                    alu_data1  = regs[src1];
                    alu_data2  = regs[src2];
                end
                OP_ADD: begin
                    alu_select = 3'd1;
                    alu_data1  = regs[src1];
                    alu_data2  = regs[src2];
                end
                OP_SUB: begin
                    // Subtraction reuses the adder with a two's-complement operand.
                    alu_select = 3'd1;
                    alu_data1  = regs[src1];
                    alu_data2  = (~regs[src2]) + 8'd1;
                end
                OP_AND: begin
                    alu_select = 3'd2;
                    alu_data1  = regs[src1];
                    alu_data2  = regs[src2];
                end
                OP_OR: begin
                    alu_select = 3'd3;
                    alu_data1  = regs[src1];
                    alu_data2  = regs[src2];
                end
                default: begin
                    alu_select = 3'd0;
                    alu_data1  = 8'd0;
                    alu_data2  = 8'd0;
                end
            endcase
        end
    end

    // Sequencer FSM, register file write and registered write-back/illegal pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ir       <= 32'd0;
            wb_valid <= 1'b0;
            wb_reg   <= 3'd0;
            wb_data  <= 8'd0;
            illegal  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    wb_valid <= 1'b0;
                    illegal  <= 1'b0;
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (legal) begin
                        regs[dest] <= alu_result;
                        wb_valid   <= 1'b1;
                        wb_reg     <= dest;
                        wb_data    <= alu_result;
                        illegal    <= 1'b0;
                    end else begin
                        wb_valid   <= 1'b0;
                        illegal    <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    wb_valid <= 1'b0;
                    illegal  <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    wb_valid <= 1'b0;
                    illegal  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with a behavioural ALU in the loop.
module tb_alu_op_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  alu_data1;
    logic [7:0]  alu_data2;
    logic [2:0]  alu_select;
    logic [7:0]  alu_result;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic [7:0]  wb_data;
    logic        illegal;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;
    logic [1:0]  dbg_state;

    int checks;
    int failures;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    alu_op_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_data1   (alu_data1),
        .alu_data2   (alu_data2),
        .alu_select  (alu_select),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .dbg_state   (dbg_state)
    );

    // Clock and external combinational ALU.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_result = 8'd0;
        case (alu_select)
            3'd0: alu_result = alu_data2;
            3'd1: alu_result = alu_data1 + alu_data2;
            3'd2: alu_result = alu_data1 & alu_data2;
            3'd3: alu_result = alu_data1 | alu_data2;
            default: alu_result = 8'd0;
        endcase
    end

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] d,
                                       input logic [7:0] s1, input logic [7:0] s2);
        return {op, d, s1, s2};
    endfunction

    // Driver: present one instruction, wait (bounded) for acceptance, and capture
    // the EXEC-phase ALU drive and the DONE-phase write-back outputs.
    task automatic run_instr(input logic [31:0] i,
                             output logic [7:0] d1, output logic [7:0] d2,
                             output logic [2:0] sel, output logic rdy_exec,
                             output logic wbv_exec, output logic wbv,
                             output logic [2:0] wbr, output logic [7:0] wbd,
                             output logic ill, output logic pulse_after);
        int n;
        n = 0;
        @(negedge clk);
        instr       = i;
        instr_valid = 1'b1;
        while (!instr_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            $display("FAIL accept_timeout instr_ready=%0b required=1", instr_ready);
            failures++;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        d1       = alu_data1;
        d2       = alu_data2;
        sel      = alu_select;
        rdy_exec = instr_ready;
        wbv_exec = wb_valid | illegal;
        @(negedge clk);
        wbv = wb_valid;
        wbr = wb_reg;
        wbd = wb_data;
        ill = illegal;
        @(negedge clk);
        pulse_after = wb_valid | illegal;
    endtask

    logic [7:0] d1, d2, wbd;
    logic [2:0] sel, wbr;
    logic       rdy_exec, wbv_exec, wbv, ill, pulse_after;

    task automatic test_reset();
        reset       = 1'b0;
        instr       = 32'd0;
        instr_valid = 1'b0;
        dbg_addr    = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            $display("FAIL reset_ready got=%0b exp=1", instr_ready); failures++;
        end
        checks++;
        if (dbg_state !== S_IDLE) begin
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); failures++;
        end
        checks++;
        if ({wb_valid, wb_reg, wb_data, illegal} !== 13'd0) begin
            $display("FAIL reset_wb got v=%0b r=%0d d=%0d ill=%0b exp all 0",
                     wb_valid, wb_reg, wb_data, illegal); failures++;
        end
        checks++;
        if ({alu_data1, alu_data2, alu_select} !== 19'd0) begin
            $display("FAIL reset_alu got d1=%0d d2=%0d sel=%0d exp 0", alu_data1, alu_data2, alu_select);
            failures++;
        end
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            checks++;
            if (dbg_data !== 8'd0) begin
                $display("FAIL reset_reg r%0d got=%0d exp=0", r, dbg_data); failures++;
            end
        end
    endtask

    task automatic test_loadi();
        run_instr(mk(8'd0, 8'd1, 8'd0, 8'd25), d1, d2, sel, rdy_exec, wbv_exec, wbv, wbr, wbd, ill, pulse_after);
        checks++;
        if ({d1, d2, sel} !== {8'd0, 8'd25, 3'd0}) begin
            $display("FAIL loadi_alu got d1=%0d d2=%0d sel=%0d exp 0/25/0", d1, d2, sel); failures++;
        end
        checks++;
        if (rdy_exec !== 1'b0 || wbv_exec !== 1'b0) begin
            $display("FAIL loadi_exec_flags got ready=%0b pulse=%0b exp 0/0", rdy_exec, wbv_exec); failures++;
        end
        checks++;
        if ({wbv, wbr, wbd, ill} !== {1'b1, 3'd1, 8'd25, 1'b0}) begin
            $display("FAIL loadi_wb got v=%0b r=%0d d=%0d ill=%0b exp 1/1/25/0", wbv, wbr, wbd, ill); failures++;
        end
        checks++;
        if (pulse_after !== 1'b0) begin
            $display("FAIL loadi_pulse_len got=%0b exp=0", pulse_after); failures++;
        end
        dbg_addr = 3'd1;
        #1;
        checks++;
        if (dbg_data !== 8'd25) begin
            $display("FAIL loadi_dbg_r1 got=%0d exp=25", dbg_data); failures++;
        end
    endtask

    task automatic test_add_sub();
        run_instr(mk(8'd0, 8'd2, 8'd0, 8'd41), d1, d2, sel, rdy_exec, wbv_exec, wbv, wbr, wbd, ill, pulse_after);
        run_instr(mk(8'd2, 8'd3, 8'd1, 8'd2), d1, d2, sel, rdy_exec, wbv_exec, wbv, wbr, wbd, ill, pulse_after);
        checks++;
        if ({sel, wbv, wbr, wbd} !== {3'd1, 1'b1, 3'd3, 8'd66}) begin
            $display("FAIL add_r3 got sel=%0d v=%0b r=%0d d=%0d exp 1/1/3/66", sel, wbv, wbr, wbd); failures++;
        end
        run_instr(mk(8'd3, 8'd4, 8'd2, 8'd1), d1, d2, sel, rdy_exec, wbv_exec, wbv, wbr, wbd, ill, pulse_after);
        checks++;
        if ({d1, d2, sel} !== {8'd41, 8'hE7, 3'd1}) begin
            $display("FAIL sub_alu got d1=%0d d2=%0h sel=%0d exp 41/e7/1", d1, d2, sel); failures++;
        end
        checks++;
        if ({wbv, wbr, wbd} !== {1'b1, 3'd4, 8'd16}) begin
            $display("FAIL sub_r4 got v=%0b r=%0d d=%0d exp 1/4/16", wbv, wbr, wbd); failures++;
        end
        run_instr(mk(8'd3, 8'd5, 8'd1, 8'd2), d1, d2, sel, rdy_exec, wbv_exec, wbv, wbr, wbd, ill, pulse_after);
        checks++;
        if ({wbv, wbr, wbd} !== {1'b1, 3'd5, 8'd240}) begin
            $display("FAIL sub_r5 got v=%0b r=%0d d=%0d exp 1/5/240", wbv, wbr, wbd); failures++;
        end
    endtask

    task automatic test_logic_wrap();
        run_instr(mk(8'd0, 8'd1, 8'd0, 8'h0E), d1, d2, sel, rdy_exec, wbv_exec, wbv, wbr, wbd, ill, pulse_after);
        run_instr(mk(8'd0, 8'd2, 8'd0, 8'h35), d1, d2, sel, rdy_exec, wbv_exec, wbv, wbr, wbd, ill, pulse_after);
        run_instr(mk(8'd4, 8'd6, 8'd1, 8'd2), d1, d2, sel, rdy_exec, wbv_exec, wbv, wbr, wbd, ill, pulse_after);
        checks++;
        if ({sel, wbr, wbd} !== {3'd2, 3'd6, 8'h04}) begin
            $display("FAIL and_r6 got sel=%0d r=%0d d=%0h exp 2/6/04", sel, wbr, wbd); failures++;
        end
        run_instr(mk(8'd5, 8'd7, 8'd1, 8'd2), d1, d2, sel, rdy_exec, wbv_exec, wbv, wbr, wbd, ill, pulse_after);
        checks++;
        if ({sel, wbr, wbd} !== {3'd3, 3'd7, 8'h3F}) begin
            $display("FAIL or_r7 got sel=%0d r=%0d d=%0h exp 3/7/3f", sel, wbr, wbd); failures++;
        end
        run_instr(mk(8'd0, 8'd3, 8'd0, 8'd152), d1, d2, sel, rdy_exec, wbv_exec, wbv, wbr, wbd, ill, pulse_after);
        run_instr(mk(8'd2, 8'd4, 8'd3, 8'd3), d1, d2, sel, rdy_exec, wbv_exec, wbv, wbr, wbd, ill, pulse_after);
        checks++;
        if ({wbv, wbr, wbd} !== {1'b1, 3'd4, 8'd48}) begin
            $display("FAIL add_wrap got v=%0b r=%0d d=%0d exp 1/4/48", wbv, wbr, wbd); failures++;
        end
    endtask

    task automatic test_illegal();
        logic [7:0] exp_regs [8];
        exp_regs = '{8'd0, 8'h0E, 8'h35, 8'd152, 8'd48, 8'd240, 8'h04, 8'h3F};
        run_instr(mk(8'h09, 8'd1, 8'd2, 8'd3), d1, d2, sel, rdy_exec, wbv_exec, wbv, wbr, wbd, ill, pulse_after);
        checks++;
        if ({ill, wbv} !== 2'b10) begin
            $display("FAIL illegal_pulse got ill=%0b v=%0b exp 1/0", ill, wbv); failures++;
        end
        checks++;
        if (pulse_after !== 1'b0 || wbv_exec !== 1'b0) begin
            $display("FAIL illegal_pulse_len got after=%0b exec=%0b exp 0/0", pulse_after, wbv_exec); failures++;
        end
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            checks++;
            if (dbg_data !== exp_regs[r]) begin
                $display("FAIL illegal_reg r%0d got=%0d exp=%0d", r, dbg_data, exp_regs[r]); failures++;
            end
        end
    endtask

    task automatic test_back_to_back();
        run_instr(mk(8'd0, 8'd1, 8'd0, 8'd3), d1, d2, sel, rdy_exec, wbv_exec, wbv, wbr, wbd, ill, pulse_after);
        @(negedge clk);
        instr       = mk(8'd2, 8'd1, 8'd1, 8'd1);
        instr_valid = 1'b1;
        checks++;
        if (instr_ready !== 1'b1) begin
            $display("FAIL b2b_ready_idle got=%0b exp=1", instr_ready); failures++;
        end
        @(negedge clk);
        checks++;
        if ({dbg_state, alu_data1, alu_data2} !== {S_EXEC, 8'd3, 8'd3}) begin
            $display("FAIL b2b_add_exec got st=%0d d1=%0d d2=%0d exp 1/3/3", dbg_state, alu_data1, alu_data2);
            failures++;
        end
        // Change instr while busy; the latched add must be unaffected.
        instr = mk(8'd1, 8'd2, 8'd0, 8'd1);
        @(negedge clk);
        checks++;
        if ({instr_ready, wb_valid, wb_reg, wb_data} !== {1'b0, 1'b1, 3'd1, 8'd6}) begin
            $display("FAIL b2b_add_wb got rdy=%0b v=%0b r=%0d d=%0d exp 0/1/1/6",
                     instr_ready, wb_valid, wb_reg, wb_data); failures++;
        end
        @(negedge clk);
        checks++;
        if ({dbg_state, instr_ready} !== {S_IDLE, 1'b1}) begin
            $display("FAIL b2b_idle got st=%0d rdy=%0b exp 0/1", dbg_state, instr_ready); failures++;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if ({dbg_state, alu_data2} !== {S_EXEC, 8'd6}) begin
            $display("FAIL b2b_mov_exec got st=%0d d2=%0d exp 1/6", dbg_state, alu_data2); failures++;
        end
        @(negedge clk);
        checks++;
        if ({wb_valid, wb_reg, wb_data} !== {1'b1, 3'd2, 8'd6}) begin
            $display("FAIL b2b_mov_wb got v=%0b r=%0d d=%0d exp 1/2/6", wb_valid, wb_reg, wb_data);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (dbg_state !== S_IDLE) begin
            $display("FAIL b2b_final_state got=%0d exp=0", dbg_state); failures++;
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        instr       = mk(8'd0, 8'd1, 8'd0, 8'd99);
        instr_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (dbg_state !== S_EXEC) begin
            $display("FAIL abort_in_exec got=%0d exp=1", dbg_state); failures++;
        end
        // instr_valid stays high across the reset edge: reset must win.
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({dbg_state, instr_ready, wb_valid, illegal} !== {S_IDLE, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL abort_reset got st=%0d rdy=%0b v=%0b ill=%0b exp 0/1/0/0",
                     dbg_state, instr_ready, wb_valid, illegal); failures++;
        end
        instr_valid = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        dbg_addr = 3'd1;
        #1;
        checks++;
        if ({dbg_data, wb_valid, dbg_state} !== {8'd0, 1'b0, S_IDLE}) begin
            $display("FAIL abort_after got r1=%0d v=%0b st=%0d exp 0/0/0", dbg_data, wb_valid, dbg_state);
            failures++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_loadi();
        test_add_sub();
        test_logic_wrap();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog_timeout elapsed=100000 required=<100000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port RESET  input  1  synchronous, active-low reset, sampled on rising CLK.
REQ-003 SHALL have port INSTR  input  32  instruction: [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2 or immediate; register indices use bits [2:0] of each field.
REQ-004 SHALL have port INSTR_VALID  input  1  INSTR is valid this cycle.
REQ-005 SHALL have port INSTR_READY  output  1  block can accept an instruction this cycle.
REQ-006 SHALL have port ALU_DATA1  output  8  first operand to ALU.
REQ-007 SHALL have port ALU_DATA2  output  8  second operand to ALU.
REQ-008 SHALL have port ALU_SELECT  output  3  ALU operation: 0 forward DATA2, 1 add, 2 and, 3 or.
REQ-009 SHALL have port ALU_RESULT  input  8  combinational ALU result.
REQ-010 SHALL have port WB_VALID  output  1  one-cycle pulse, register write completed.
REQ-011 SHALL have port WB_REG  output  3  register written.
REQ-012 SHALL have port WB_DATA  output  8  value written.
REQ-013 SHALL have port ILLEGAL  output  1  one-cycle pulse, undefined opcode was dropped.
REQ-014 SHALL have port DBG_ADDR  input  3  debug read index.
REQ-015 SHALL have port DBG_DATA  output  8  combinational reg[DBG_ADDR].

Function
REQ-016 SHALL contain an 8 x 8-bit register file, indices 0-7, all writable; no hard-wired zero register.
REQ-017 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE.
REQ-018 INSTR_READY SHALL be 1 only in IDLE.
REQ-019 In IDLE, INSTR_VALID=1 at a rising edge SHALL latch INSTR and move to EXEC; INSTR_VALID=0 SHALL keep IDLE.
REQ-020 In EXEC, ALU_* SHALL be driven combinationally from the latched instruction and the current register file.
REQ-021 Opcode decode SHALL be: 0 loadi (SELECT 0, DATA2=imm); 1 mov (SELECT 0, DATA2=reg[src2]); 2 add (SELECT 1); 3 sub (SELECT 1, DATA2=(~reg[src2]+1) mod 256); 4 and (SELECT 2); 5 or (SELECT 3).
REQ-022 For opcodes 1-5, ALU_DATA1 SHALL be reg[src1] and ALU_DATA2 SHALL be reg[src2] unless REQ-021 states otherwise; for loadi, ALU_DATA1 SHALL be 0.
REQ-023 At the EXEC->DONE edge, a legal opcode SHALL write ALU_RESULT to reg[dest] and register WB_VALID=1, WB_REG=dest, WB_DATA=ALU_RESULT.
REQ-024 For opcodes 6-255, the block SHALL write no register, SHALL register ILLEGAL=1 and WB_VALID=0, and SHALL still pass through DONE.
REQ-025 DONE SHALL last exactly one cycle; WB_VALID and ILLEGAL SHALL be 0 in every other state.
REQ-026 Arithmetic SHALL be 8-bit modulo 256 with no carry or overflow output.
REQ-027 Latency SHALL be: accept edge E0, write at E1, INSTR_READY high again after E2; throughput is one instruction per 3 cycles.
REQ-028 When dest equals src1 or src2, EXEC SHALL read the old value and the new value SHALL take effect after E1.
REQ-029 An instruction accepted after E2 SHALL see every earlier write; no forwarding path is required.
REQ-030 Outside EXEC, ALU_DATA1, ALU_DATA2 and ALU_SELECT SHALL be 0.
REQ-031 INSTR SHALL be ignored while INSTR_READY=0.

Reset
REQ-032 RESET=0 at a rising edge SHALL clear all registers to 0, go to IDLE, and force WB_VALID=0, WB_REG=0, WB_DATA=0 and ILLEGAL=0.
REQ-033 After reset, INSTR_READY SHALL be 1.
REQ-034 Reset asserted in EXEC or DONE SHALL abort the instruction with no register write and no WB_VALID or ILLEGAL pulse.
REQ-035 RESET SHALL take priority over INSTR_VALID on the same edge.

Verification
REQ-036 Reset, then loadi r1,25 -> WB_VALID pulse 2 cycles after accept, WB_REG=1, WB_DATA=25, DBG r1=25.
REQ-037 r1=25, r2=41, add r3,r1,r2 -> WB_DATA=66; sub r4,r2,r1 -> ALU_DATA2=0xE7 in EXEC, WB_DATA=16; sub r5,r1,r2 -> 240.
REQ-038 r1=0x0E, r2=0x35: and r6,r1,r2 -> 0x04; or r7,r1,r2 -> 0x3F; add of 152+152 -> 48 (wrap).
REQ-039 Opcode 0x09 -> ILLEGAL pulse in DONE, WB_VALID=0, all registers unchanged.
REQ-040 INSTR_VALID held high with back-to-back instructions -> one accept per 3 cycles; add r1,r1,r1 with r1=3 -> 6, a following mov r2,r1 -> 6.
REQ-041 RESET=0 during EXEC of loadi r1,99 -> r1=0, no WB_VALID, IDLE next cycle.
